// File: rtl/approx_mult_sweep_ctrl.sv
// Error-characterisation sequencer for an external approximate multiplier: sweeps every
// operand pair, compares each returned product with the exact one and accumulates error stats.
module approx_mult_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_result,
    output logic                 busy,
    output logic                 done,
    output logic [4*WIDTH-1:0]   err_sum,
    output logic [2*WIDTH:0]     mismatch_cnt,
    output logic [2*WIDTH-1:0]   max_err,
    output logic [WIDTH-1:0]     max_a,
    output logic [WIDTH-1:0]     max_b
);

    localparam int PW = 2 * WIDTH;
    localparam int WW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   cnt;
    logic [WW-1:0]   wait_cnt;
    logic [PW-1:0]   exact;
    logic [PW-1:0]   diff;
    logic            sample;

    function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    function automatic logic [4*WIDTH-1:0] widen_sum(input logic [PW-1:0] d);
        return {{(4*WIDTH-PW){1'b0}}, d};
    endfunction

    // The pair counter doubles as the registered operand outputs.
    assign mul_a = cnt[PW-1:WIDTH];
    assign mul_b = cnt[WIDTH-1:0];

    always_comb begin
        exact  = PW'(mul_a) * PW'(mul_b);
        diff   = abs_diff(mul_result, exact);
        sample = (wait_cnt == WW'(MUL_LAT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            wait_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_sum      <= '0;
            mismatch_cnt <= '0;
            max_err      <= '0;
            max_a        <= '0;
            max_b        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= RUN;
                        cnt          <= '0;
                        wait_cnt     <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err_sum      <= '0;
                        mismatch_cnt <= '0;
                        max_err      <= '0;
                        max_a        <= '0;
                        max_b        <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // The pair in flight is dropped; partial results stay visible.
                        state    <= IDLE;
                        wait_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                    end else if (sample) begin
                        wait_cnt     <= '0;
                        err_sum      <= err_sum + widen_sum(diff);
                        mismatch_cnt <= mismatch_cnt + (PW+1)'(diff != '0);
                        if (diff > max_err) begin
                            max_err <= diff;
                            max_a   <= mul_a;
                            max_b   <= mul_b;
                        end
                        if (cnt == '1) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
